core_mem_port: RTL and testbench

Unified memory port for the next-generation multi-cycle RV32I core. It arbitrates the core's instruction-fetch and load/store requests onto one shared valid/ready memory bus. It handles byte-lane steering, store byte enables and load sign/zero extension for a parametrised bus width, and reports misalignment and bus-timeout errors. It sits between the core's control/execution logic and the single-ported memory, replacing separate program and data ports.

---
 rtl/core_mem_port.sv | 222 ++++++++++++++++++++++
 tb/tb_core_mem_port.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_port.sv
// Shared instruction/data memory port for the multi-cycle RV32I core: arbitrates
// fetch and load/store onto one valid/ready bus with lane steering and extension.
module core_mem_port #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_ready_o,
  output logic                    if_rvalid_o,
  output logic [31:0]             if_rdata_o,
  output logic                    if_err_o,
  input  logic                    ls_valid_i,
  input  logic                    ls_we_i,
  input  logic [1:0]              ls_size_i,
  input  logic                    ls_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]   ls_addr_i,
  input  logic [DATA_WIDTH-1:0]   ls_wdata_i,
  output logic                    ls_ready_o,
  output logic                    ls_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ls_rdata_o,
  output logic                    ls_err_o,
  output logic                    mem_valid_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_ready_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int STRB = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(STRB);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                r_state;
  logic                  r_lastData;
  logic                  r_ownerData;
  logic                  r_memValid;
  logic                  r_we;
  logic                  r_unsigned;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [TW-1:0]         r_timer;
  logic                  r_ifRvalid;
  logic                  r_ifErr;
  logic [31:0]           r_ifRdata;
  logic                  r_lsRvalid;
  logic                  r_lsErr;
  logic [DATA_WIDTH-1:0] r_lsRdata;

  logic                  w_grantData;
  logic                  w_grantIf;
  logic                  w_accept;
  logic [1:0]            w_reqSize;
  logic [ADDR_WIDTH-1:0] w_reqAddr;
  logic                  w_reqIllegal;
  logic [OFFW-1:0]       w_off;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_wdataRep;
  logic [STRB-1:0]       w_be;
  logic                  w_sign;

  // On a tie the client that did not win last time gets the bus.
  assign w_grantData = ls_valid_i && (!if_valid_i || !r_lastData);
  assign w_grantIf   = if_valid_i && !w_grantData;
  assign w_accept    = (r_state == IDLE) && (w_grantData || w_grantIf);
  assign if_ready_o  = (r_state == IDLE) && w_grantIf;
  assign ls_ready_o  = (r_state == IDLE) && w_grantData;

  // A fetch is treated as a word access for alignment and steering.
  assign w_reqSize = w_grantData ? ls_size_i : 2'd2;
  assign w_reqAddr = w_grantData ? ls_addr_i : if_addr_i;

  always_comb begin
    w_reqIllegal = 1'b0;
    case (w_reqSize)
      2'd1:    w_reqIllegal = w_reqAddr[0];
      2'd2:    w_reqIllegal = |w_reqAddr[1:0];
      2'd3:    w_reqIllegal = (DATA_WIDTH == 32) || (|w_reqAddr[2:0]);
      default: w_reqIllegal = 1'b0;
    endcase
  end

  assign w_off     = r_addr[OFFW-1:0];
  assign w_shifted = mem_rdata_i >> {w_off, 3'b000};

  // Lane steering: the mask keeps the selected bytes, the rest is filled by extension.
  always_comb begin
    w_mask     = '1;
    w_sign     = 1'b0;
    w_be       = '1;
    w_wdataRep = r_wdata;
    case (r_size)
      2'd0: begin
        w_mask     = DATA_WIDTH'(8'hFF);
        w_sign     = w_shifted[7];
        w_be       = STRB'(1) << w_off;
        w_wdataRep = {STRB{r_wdata[7:0]}};
      end
      2'd1: begin
        w_mask     = DATA_WIDTH'(16'hFFFF);
        w_sign     = w_shifted[15];
        w_be       = STRB'(2'b11) << w_off;
        w_wdataRep = {(STRB/2){r_wdata[15:0]}};
      end
      2'd2: begin
        w_mask     = DATA_WIDTH'(32'hFFFF_FFFF);
        w_sign     = w_shifted[31];
        w_be       = STRB'(4'hF) << w_off;
        w_wdataRep = {(STRB/4){r_wdata[31:0]}};
      end
      default: begin
      end
    endcase
    if (!r_ownerData) begin
      w_be = '1;
    end
    w_load = (w_shifted & w_mask) | ((w_sign && !r_unsigned) ? ~w_mask : '0);
  end

  assign mem_valid_o = r_memValid;
  assign mem_we_o    = r_memValid && r_we;
  assign mem_addr_o  = r_memValid ? {r_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}} : '0;
  assign mem_be_o    = r_memValid ? w_be : '0;
  assign mem_wdata_o = r_memValid ? w_wdataRep : '0;

  assign if_rvalid_o = r_ifRvalid;
  assign if_err_o    = r_ifErr;
  assign if_rdata_o  = r_ifRdata;
  assign ls_rvalid_o = r_lsRvalid;
  assign ls_err_o    = r_lsErr;
  assign ls_rdata_o  = r_lsRdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lastData  <= 1'b0;
      r_ownerData <= 1'b0;
      r_memValid  <= 1'b0;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_timer     <= '0;
      r_ifRvalid  <= 1'b0;
      r_ifErr     <= 1'b0;
      r_ifRdata   <= '0;
      r_lsRvalid  <= 1'b0;
      r_lsErr     <= 1'b0;
      r_lsRdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_lastData  <= w_grantData;
            r_ownerData <= w_grantData;
            r_we        <= w_grantData && ls_we_i;
            r_unsigned  <= ls_unsigned_i;
            r_size      <= w_reqSize;
            r_addr      <= w_reqAddr;
            r_wdata     <= ls_wdata_i;
            r_timer     <= '0;
            if (w_reqIllegal) begin
              r_state    <= RESP;
              r_ifRvalid <= w_grantIf;
              r_ifErr    <= w_grantIf;
              r_lsRvalid <= w_grantData;
              r_lsErr    <= w_grantData;
            end else begin
              r_state    <= BUSY;
              r_memValid <= 1'b1;
            end
          end
        end
        BUSY: begin
          // A completion in the last allowed cycle still wins over the timeout.
          if (mem_ready_i) begin
            r_state    <= RESP;
            r_memValid <= 1'b0;
            if (r_ownerData) begin
              r_lsRvalid <= 1'b1;
              r_lsRdata  <= r_we ? '0 : w_load;
            end else begin
              r_ifRvalid <= 1'b1;
              r_ifRdata  <= w_shifted[31:0];
            end
          end else if ((TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1))) begin
            r_state    <= RESP;
            r_memValid <= 1'b0;
            r_ifRvalid <= !r_ownerData;
            r_ifErr    <= !r_ownerData;
            r_lsRvalid <= r_ownerData;
            r_lsErr    <= r_ownerData;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RESP: begin
          r_state    <= IDLE;
          r_ifRvalid <= 1'b0;
          r_ifErr    <= 1'b0;
          r_ifRdata  <= '0;
          r_lsRvalid <= 1'b0;
          r_lsErr    <= 1'b0;
          r_lsRdata  <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_port.sv
// Randomised bench for core_mem_port: a 32-bit port with TIMEOUT=4 and a 64-bit port
// without timeout, both checked against a byte-level reference model.
module tb_core_mem_port;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          sel64;
  logic          ifValid, lsValid, lsWe, lsUnsigned, memReady;
  logic [1:0]    lsSize;
  logic [AW-1:0] ifAddr, lsAddr;
  logic [63:0]   lsWdata, memRdata;

  logic          aIfReady, aIfRvalid, aIfErr, aLsReady, aLsRvalid, aLsErr, aMemValid, aMemWe;
  logic [31:0]   aIfRdata, aLsRdata, aMemWdata;
  logic [AW-1:0] aMemAddr;
  logic [3:0]    aMemBe;
  logic          bIfReady, bIfRvalid, bIfErr, bLsReady, bLsRvalid, bLsErr, bMemValid, bMemWe;
  logic [31:0]   bIfRdata;
  logic [63:0]   bLsRdata, bMemWdata;
  logic [AW-1:0] bMemAddr;
  logic [7:0]    bMemBe;

  core_mem_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .rst(rst),
    .if_valid_i(ifValid & ~sel64), .if_addr_i(ifAddr), .if_ready_o(aIfReady),
    .if_rvalid_o(aIfRvalid), .if_rdata_o(aIfRdata), .if_err_o(aIfErr),
    .ls_valid_i(lsValid & ~sel64), .ls_we_i(lsWe), .ls_size_i(lsSize),
    .ls_unsigned_i(lsUnsigned), .ls_addr_i(lsAddr), .ls_wdata_i(lsWdata[31:0]),
    .ls_ready_o(aLsReady), .ls_rvalid_o(aLsRvalid), .ls_rdata_o(aLsRdata), .ls_err_o(aLsErr),
    .mem_valid_o(aMemValid), .mem_we_o(aMemWe), .mem_addr_o(aMemAddr), .mem_be_o(aMemBe),
    .mem_wdata_o(aMemWdata), .mem_ready_i(memReady & ~sel64), .mem_rdata_i(memRdata[31:0])
  );

  core_mem_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(64), .TIMEOUT(0)) u_dut64 (
    .clk(clk), .rst(rst),
    .if_valid_i(ifValid & sel64), .if_addr_i(ifAddr), .if_ready_o(bIfReady),
    .if_rvalid_o(bIfRvalid), .if_rdata_o(bIfRdata), .if_err_o(bIfErr),
    .ls_valid_i(lsValid & sel64), .ls_we_i(lsWe), .ls_size_i(lsSize),
    .ls_unsigned_i(lsUnsigned), .ls_addr_i(lsAddr), .ls_wdata_i(lsWdata),
    .ls_ready_o(bLsReady), .ls_rvalid_o(bLsRvalid), .ls_rdata_o(bLsRdata), .ls_err_o(bLsErr),
    .mem_valid_o(bMemValid), .mem_we_o(bMemWe), .mem_addr_o(bMemAddr), .mem_be_o(bMemBe),
    .mem_wdata_o(bMemWdata), .mem_ready_i(memReady & sel64), .mem_rdata_i(memRdata)
  );

  logic          obsIfReady, obsLsReady, obsIfRvalid, obsLsRvalid, obsIfErr, obsLsErr;
  logic          obsMemValid, obsMemWe;
  logic [31:0]   obsIfRdata;
  logic [63:0]   obsLsRdata, obsMemWdata;
  logic [AW-1:0] obsMemAddr;
  logic [7:0]    obsMemBe;

  assign obsIfReady  = sel64 ? bIfReady  : aIfReady;
  assign obsLsReady  = sel64 ? bLsReady  : aLsReady;
  assign obsIfRvalid = sel64 ? bIfRvalid : aIfRvalid;
  assign obsLsRvalid = sel64 ? bLsRvalid : aLsRvalid;
  assign obsIfErr    = sel64 ? bIfErr    : aIfErr;
  assign obsLsErr    = sel64 ? bLsErr    : aLsErr;
  assign obsMemValid = sel64 ? bMemValid : aMemValid;
  assign obsMemWe    = sel64 ? bMemWe    : aMemWe;
  assign obsIfRdata  = sel64 ? bIfRdata  : aIfRdata;
  assign obsLsRdata  = sel64 ? bLsRdata  : {32'b0, aLsRdata};
  assign obsMemWdata = sel64 ? bMemWdata : {32'b0, aMemWdata};
  assign obsMemAddr  = sel64 ? bMemAddr  : aMemAddr;
  assign obsMemBe    = sel64 ? bMemBe    : {4'b0, aMemBe};

  int checks = 0;
  int errors = 0;
  // Round-robin history per port: 1 means the data client won the last grant.
  bit lastData [2];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit isLegal(input bit isFetch, input logic [1:0] size, input int addr,
                                 input int dw);
    if (isFetch) return (addr % 4) == 0;
    case (size)
      2'd0:    return 1'b1;
      2'd1:    return (addr % 2) == 0;
      2'd2:    return (addr % 4) == 0;
      default: return (dw == 64) && ((addr % 8) == 0);
    endcase
  endfunction

  function automatic logic [63:0] expBe(input bit isFetch, input logic [1:0] size,
                                        input int addr, input int dw);
    int strb = dw / 8;
    int off = addr % strb;
    int n = 1 << size;
    logic [63:0] r = '0;
    if (isFetch || size == 2'd3) begin
      n = strb;
      off = 0;
    end
    for (int i = 0; i < n; i++) r[off + i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] expWdata(input logic [1:0] size, input logic [63:0] wdata,
                                           input int dw);
    int n = 1 << size;
    logic [63:0] r = '0;
    for (int i = 0; i < dw / 8; i++) r[i*8 +: 8] = wdata[(i % n)*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] expRdata(input bit isFetch, input bit we, input logic [1:0] size,
                                           input bit uns, input int addr, input logic [63:0] rdata,
                                           input int dw);
    int n = isFetch ? 4 : (1 << size);
    int off = addr % (dw / 8);
    logic [63:0] r = '0;
    if (!isFetch && we) return '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = rdata[(off + i)*8 +: 8];
    if (!isFetch && !uns && r[n*8 - 1]) begin
      for (int b = n * 8; b < dw; b++) r[b] = 1'b1;
    end
    return r;
  endfunction

  // Every DUT output must read zero on both ports while reset is in effect.
  task automatic checkResetState(input string tag);
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      #1;
      checkOutput({tag, "_mem_valid"}, obsMemValid, 0);
      checkOutput({tag, "_mem_we"}, obsMemWe, 0);
      checkOutput({tag, "_mem_addr"}, obsMemAddr, 0);
      checkOutput({tag, "_mem_be"}, obsMemBe, 0);
      checkOutput({tag, "_mem_wdata"}, obsMemWdata, 0);
      checkOutput({tag, "_rdy"}, {obsIfReady, obsLsReady}, 0);
      checkOutput({tag, "_rvalid"}, {obsIfRvalid, obsLsRvalid, obsIfErr, obsLsErr}, 0);
      checkOutput({tag, "_rdata"}, obsLsRdata | {32'b0, obsIfRdata}, 0);
    end
    sel64 = 1'b0;
  endtask

  // One complete transaction on the selected port; memory answers in BUSY cycle k.
  task automatic applyStimulus(input bit useIf, input bit useLs, input logic [AW-1:0] fAddr,
                               input bit we, input logic [1:0] size, input bit uns,
                               input logic [AW-1:0] dAddr, input logic [63:0] wdata,
                               input int k, input logic [63:0] rdata, output logic [63:0] got);
    int dw, to, sIdx, addr, busy;
    bit ownerData, legal, timedOut, errExp;
    logic [63:0] expR;
    dw = sel64 ? 64 : 32;
    to = sel64 ? 0 : 4;
    sIdx = sel64 ? 1 : 0;
    ownerData = useLs && (!useIf || !lastData[sIdx]);
    addr = ownerData ? int'(dAddr) : int'(fAddr);
    legal = isLegal(!ownerData, size, addr, dw);
    timedOut = legal && (to != 0) && (k > to);
    busy = timedOut ? to : k;
    errExp = !legal || timedOut;
    expR = errExp ? 64'h0 : expRdata(!ownerData, we, size, uns, addr, rdata, dw);

    @(negedge clk);
    ifValid = useIf; ifAddr = fAddr;
    lsValid = useLs; lsWe = we; lsSize = size; lsUnsigned = uns; lsAddr = dAddr; lsWdata = wdata;
    memReady = 1'($urandom_range(0, 1));
    memRdata = {$urandom, $urandom};
    #1;
    checkOutput("idle_rvalid", {obsIfRvalid, obsLsRvalid}, 0);
    checkOutput("idle_mem_valid", obsMemValid, 0);
    checkOutput("if_ready", obsIfReady, useIf && !ownerData);
    checkOutput("ls_ready", obsLsReady, ownerData);
    lastData[sIdx] = ownerData;

    @(negedge clk);
    if (ownerData) begin
      lsValid = 1'b0; lsAddr = AW'($urandom); lsWdata = {$urandom, $urandom};
      lsSize = 2'($urandom); lsWe = 1'($urandom); lsUnsigned = 1'($urandom);
    end else begin
      ifValid = 1'b0; ifAddr = AW'($urandom);
    end
    memReady = 1'b0;
    if (legal) begin
      for (int c = 1; c <= busy; c++) begin
        if (c > 1) @(negedge clk);
        memReady = (c == k);
        memRdata = (c == k) ? rdata : {$urandom, $urandom};
        #1;
        checkOutput("busy_mem_valid", obsMemValid, 1);
        checkOutput("busy_rvalid", {obsIfRvalid, obsLsRvalid}, 0);
        checkOutput("busy_rdy", {obsIfReady, obsLsReady}, 0);
        if (c == 1) begin
          checkOutput("mem_addr", obsMemAddr, 64'(addr - (addr % (dw / 8))));
          checkOutput("mem_be", obsMemBe, expBe(!ownerData, size, addr, dw));
          checkOutput("mem_we", obsMemWe, ownerData && we);
          if (ownerData && we) checkOutput("mem_wdata", obsMemWdata, expWdata(size, wdata, dw));
        end
      end
      @(negedge clk);
      memReady = 1'($urandom_range(0, 1));
      memRdata = {$urandom, $urandom};
    end
    #1;
    checkOutput("resp_mem_valid", obsMemValid, 0);
    checkOutput("resp_rdy", {obsIfReady, obsLsReady}, 0);
    checkOutput("resp_rvalid", ownerData ? obsLsRvalid : obsIfRvalid, 1);
    checkOutput("resp_err", ownerData ? obsLsErr : obsIfErr, errExp);
    checkOutput("resp_rdata", ownerData ? obsLsRdata : {32'b0, obsIfRdata}, expR);
    checkOutput("other_rvalid", ownerData ? {obsIfRvalid, obsIfErr} : {obsLsRvalid, obsLsErr}, 0);
    checkOutput("other_rdata", ownerData ? {32'b0, obsIfRdata} : obsLsRdata, 0);
    got = ownerData ? obsLsRdata : {32'b0, obsIfRdata};
  endtask

  // Reset sampled during BUSY on the 64-bit port abandons the load silently.
  task automatic resetDuringBusy();
    sel64 = 1'b1;
    @(negedge clk);
    lsValid = 1'b1; lsWe = 1'b0; lsSize = 2'd2; lsUnsigned = 1'b0; lsAddr = 10'h010;
    memReady = 1'b0;
    #1;
    checkOutput("mr_ls_ready", obsLsReady, 1);
    @(negedge clk);
    lsValid = 1'b0;
    #1;
    checkOutput("mr_busy_mem_valid", obsMemValid, 1);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("mr");
    rst = 1'b0;
    sel64 = 1'b1;
    memReady = 1'b1;
    @(negedge clk);
    memReady = 1'b0;
    #1;
    checkOutput("mr_no_rvalid", {obsIfRvalid, obsLsRvalid}, 0);
    checkOutput("mr_idle_mem_valid", obsMemValid, 0);
    lastData[0] = 1'b0;
    lastData[1] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0]   got;
    logic [AW-1:0] fa, da;
    logic [1:0]    sz;
    bit            tie, isF, we, uns, winner;
    int            k;
    logic [63:0]   wd, rd;

    rst = 1'b1; sel64 = 1'b0;
    ifValid = 1'b0; lsValid = 1'b0; lsWe = 1'b0; lsUnsigned = 1'b0; memReady = 1'b0;
    lsSize = 2'd0; ifAddr = '0; lsAddr = '0; lsWdata = '0; memRdata = '0;
    lastData[0] = 1'b0;
    lastData[1] = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("rst");
    rst = 1'b0;

    $display("[TB] simultaneous requests after reset");
    for (int t = 0; t < 3; t++) begin
      applyStimulus(1, 1, 10'h008, 0, 2'd2, 0, 10'h010, '0, 1, {$urandom, $urandom}, got);
      checkOutput("rr_order", lastData[0], (t != 1));
    end
    applyStimulus(1, 0, 10'h008, 0, 2'd2, 0, 10'h000, '0, 2, {$urandom, $urandom}, got);

    $display("[TB] directed 32-bit accesses");
    applyStimulus(1, 0, 10'h004, 0, 2'd2, 0, 10'h000, '0, 1, 64'h00500093, got);
    checkOutput("plan_fetch", got, 64'h00500093);
    applyStimulus(0, 1, 10'h000, 0, 2'd0, 0, 10'h013, '0, 1, 64'h80FF1234, got);
    checkOutput("plan_sbyte", got, 64'hFFFF_FF80);
    applyStimulus(0, 1, 10'h000, 0, 2'd0, 1, 10'h013, '0, 2, 64'h80FF1234, got);
    checkOutput("plan_ubyte", got, 64'h0000_0080);
    applyStimulus(0, 1, 10'h000, 1, 2'd1, 0, 10'h022, 64'h0000BEEF, 1, 64'h12345678, got);
    checkOutput("plan_store_rdata", got, 0);
    applyStimulus(0, 1, 10'h000, 0, 2'd2, 0, 10'h006, '0, 1, 64'h11111111, got);
    applyStimulus(0, 1, 10'h000, 0, 2'd2, 0, 10'h010, '0, 20, 64'h11111111, got);
    applyStimulus(0, 1, 10'h000, 0, 2'd2, 0, 10'h010, '0, 4, 64'h8000_0001, got);
    checkOutput("plan_ready_at_limit", got, 64'h8000_0001);
    applyStimulus(0, 1, 10'h000, 0, 2'd3, 0, 10'h008, '0, 1, 64'h1, got);

    $display("[TB] directed 64-bit accesses");
    sel64 = 1'b1;
    applyStimulus(1, 0, 10'h00C, 0, 2'd2, 0, 10'h000, '0, 1, 64'hDEADBEEF_00000013, got);
    checkOutput("plan_fetch64", got, 64'hDEADBEEF);
    applyStimulus(0, 1, 10'h000, 0, 2'd3, 0, 10'h008, '0, 3, 64'h81234567_89ABCDEF, got);
    checkOutput("plan_double", got, 64'h81234567_89ABCDEF);
    applyStimulus(0, 1, 10'h000, 0, 2'd2, 0, 10'h014, '0, 12, 64'hF000_0000_0000_0000, got);
    resetDuringBusy();

    $display("[TB] randomised traffic");
    for (int n = 0; n < 250; n++) begin
      sel64 = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      isF = ($urandom_range(0, 3) == 0);
      we  = 1'($urandom);
      uns = 1'($urandom);
      tie = ($urandom_range(0, 7) == 0);
      fa  = AW'($urandom);
      da  = AW'($urandom);
      if ($urandom_range(0, 3) != 0) fa = fa & ~AW'(3);
      if ($urandom_range(0, 2) != 0) da = da & ~AW'((1 << sz) - 1);
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      k  = $urandom_range(1, 6);
      if (tie) begin
        applyStimulus(1, 1, fa, we, sz, uns, da, wd, k, rd, got);
        winner = lastData[sel64 ? 1 : 0];
        applyStimulus(winner, !winner, fa, we, sz, uns, da, wd, $urandom_range(1, 6),
                      {$urandom, $urandom}, got);
      end else begin
        applyStimulus(isF, !isF, fa, we, sz, uns, da, wd, k, rd, got);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
